mtx_phase_gen: RTL and testbench

Parametrised multi-tone, multi-symbol phase sequencer for the ANC main TX path. It emits NTONES packed phase words per sample over an AXI-stream with full backpressure. The words drive a bank of downstream dds_sin_cos_lut_only instances, one per tone, whose outputs are summed with add2_and_clip. It replaces fixed two-tone phase generation with a per-tone frequency comb, explicit start/stop control, frame/sync accounting and stall-safe output registers.

---
 rtl/mtx_phase_gen_if.sv | 19 +
 rtl/mtx_phase_gen.sv | 154 +++++++++++++++
 tb/tb_mtx_phase_gen.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mtx_phase_gen_if.sv
// rtl/mtx_phase_gen_if.sv - output stream bundle of the multi-tone phase sequencer
// The guard member exists only when MTX_GUARD_EN is defined.
interface mtx_phase_gen_if #(
  parameter int PHASE_WIDTH = 24,
  parameter int NTONES      = 2
);
  logic                          tvalid;
  logic                          tready;
  logic                          tlast;
  logic [NTONES*PHASE_WIDTH-1:0] phase;
`ifdef MTX_GUARD_EN
  logic                          guard;
  modport master (output tvalid, tlast, phase, guard, input tready);
  modport slave  (input tvalid, tlast, phase, guard, output tready);
`else
  modport master (output tvalid, tlast, phase, input tready);
  modport slave  (input tvalid, tlast, phase, output tready);
`endif
endinterface

// File: rtl/mtx_phase_gen.sv
// rtl/mtx_phase_gen.sv - multi-tone, multi-symbol phase sequencer with AXI-stream output
// Optional guard samples before each symbol are enabled by defining MTX_GUARD_EN.
module mtx_phase_gen #(
  parameter int PHASE_WIDTH  = 24,
  parameter int NTONES       = 2,
  parameter int NSYMB_WIDTH  = 16,
  parameter int TX_SYNC_BITS = 5,
  parameter int NSYMB        = 8,
  parameter int NSIG         = 8192,
  parameter int START_PH_INC = 4096,
  parameter int DPH_INC      = 16384,
  parameter int FREQ_SHIFT   = 8192,
  parameter int START_PH     = 0,
  parameter int NPH_SHIFT    = 0,
  parameter int NGUARD       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   srst,
  input  logic                   en,
  mtx_phase_gen_if.master        out,
  output logic [NSYMB_WIDTH-1:0] symb_idx,
  output logic [PHASE_WIDTH-1:0] sig_idx,
  output logic                   frame_done,
  output logic                   sync_ready
);

  if (NTONES < 1 || NTONES > 8 || NSYMB < 1 || NSIG < 2 || NGUARD < 0) begin : g_bad_cfg
    $error("mtx_phase_gen: illegal parameter set");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state;
  logic [PHASE_WIDTH-1:0]   acc [NTONES];
  logic [PHASE_WIDTH-1:0]   inc [NTONES];
  logic [PHASE_WIDTH-1:0]   sym_start;
  logic [PHASE_WIDTH-1:0]   next_start;
  logic [TX_SYNC_BITS-1:0]  frame_cnt;
  logic                     xfer;
  logic                     in_guard;
  logic                     last_n;
  logic                     last_s;
  logic                     frame_end;
  logic                     start_frame;

`ifdef MTX_GUARD_EN
  localparam int GCW = (NGUARD > 1) ? $clog2(NGUARD) : 1;
  logic [GCW-1:0] guard_cnt;
  assign in_guard = out.guard;
`else
  assign in_guard = 1'b0;
`endif

  function automatic logic [PHASE_WIDTH-1:0] tone_inc0(int k);
    return PHASE_WIDTH'(START_PH_INC + k * FREQ_SHIFT);
  endfunction

  assign xfer        = out.tvalid && out.tready;
  assign last_n      = !in_guard && (sig_idx == PHASE_WIDTH'(NSIG - 1));
  assign last_s      = (symb_idx == NSYMB_WIDTH'(NSYMB - 1));
  assign frame_end   = xfer && last_n && last_s;
  // A new frame starts from IDLE or back-to-back at a frame boundary while en is held.
  assign start_frame = en && ((state == IDLE) || frame_end);
  assign next_start  = sym_start - PHASE_WIDTH'(NPH_SHIFT);
  assign sync_ready  = &frame_cnt;

  always_comb begin
    out.phase = '0;
    for (int k = 0; k < NTONES; k++) begin
      out.phase[k*PHASE_WIDTH +: PHASE_WIDTH] = acc[k];
    end
  end

  always_ff @(posedge clk) begin
    frame_done <= 1'b0;
    if (reset || srst) begin
      state      <= IDLE;
      out.tvalid <= 1'b0;
      out.tlast  <= 1'b0;
      symb_idx   <= '0;
      sig_idx    <= '0;
      sym_start  <= '0;
      frame_cnt  <= '1;
      for (int k = 0; k < NTONES; k++) begin
        acc[k] <= '0;
        inc[k] <= '0;
      end
`ifdef MTX_GUARD_EN
      out.guard <= 1'b0;
      guard_cnt <= '0;
`endif
    end else if (start_frame) begin
      state      <= RUN;
      out.tvalid <= 1'b1;
      out.tlast  <= 1'b0;
      symb_idx   <= '0;
      sig_idx    <= '0;
      sym_start  <= PHASE_WIDTH'(START_PH);
      for (int k = 0; k < NTONES; k++) begin
        acc[k] <= PHASE_WIDTH'(START_PH);
        inc[k] <= tone_inc0(k);
      end
`ifdef MTX_GUARD_EN
      out.guard <= (NGUARD > 0);
      guard_cnt <= '0;
`endif
      if (frame_end) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + TX_SYNC_BITS'(1);
      end
    end else if (frame_end) begin
      state      <= IDLE;
      out.tvalid <= 1'b0;
      out.tlast  <= 1'b0;
      symb_idx   <= '0;
      sig_idx    <= '0;
      frame_done <= 1'b1;
      frame_cnt  <= frame_cnt + TX_SYNC_BITS'(1);
    end else if (xfer) begin
`ifdef MTX_GUARD_EN
      // Guard samples repeat the n=0 phase; leaving the guard presents the real n=0 sample.
      if (in_guard) begin
        if (guard_cnt == GCW'(NGUARD - 1)) begin
          out.guard <= 1'b0;
        end else begin
          guard_cnt <= guard_cnt + GCW'(1);
        end
      end else
`endif
      if (!last_n) begin
        sig_idx   <= sig_idx + PHASE_WIDTH'(1);
        out.tlast <= (sig_idx == PHASE_WIDTH'(NSIG - 2));
        for (int k = 0; k < NTONES; k++) begin
          acc[k] <= acc[k] + inc[k];
        end
      end else begin
        symb_idx  <= symb_idx + NSYMB_WIDTH'(1);
        sig_idx   <= '0;
        out.tlast <= 1'b0;
        sym_start <= next_start;
        for (int k = 0; k < NTONES; k++) begin
          acc[k] <= next_start;
          inc[k] <= inc[k] + PHASE_WIDTH'(DPH_INC);
        end
`ifdef MTX_GUARD_EN
        out.guard <= (NGUARD > 0);
        guard_cnt <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mtx_phase_gen.sv
// tb/tb_mtx_phase_gen.sv - scoreboard bench for mtx_phase_gen with randomized backpressure
`timescale 1ns/1ps
module tb_mtx_phase_gen;
  localparam int PW    = 24;
  localparam int NT    = 2;
  localparam int NSW   = 16;
  localparam int TSB   = 2;
  localparam int NSYMB = 2;
  localparam int NSIG  = 4;
  localparam int SINC  = 16;
  localparam int DPH   = 32;
  localparam int FS    = 8;
  localparam int SPH   = 0;
  localparam int NPHS  = 4;
  localparam int NG    = 2;
`ifdef MTX_GUARD_EN
  localparam int GS = NG;
`else
  localparam int GS = 0;
`endif
  localparam int SPF = NSYMB * (GS + NSIG);

  typedef struct packed {
    logic [NT*PW-1:0] phase;
    logic             tlast;
    logic [NSW-1:0]   s;
    logic [PW-1:0]    n;
    logic             guard;
    logic             sync;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           srst = 1'b0;
  logic           en = 1'b0;
  logic [NSW-1:0] symb_idx;
  logic [PW-1:0]  sig_idx;
  logic           frame_done;
  logic           sync_ready;
  logic           rnd_ready = 1'b0;

  mtx_phase_gen_if #(.PHASE_WIDTH(PW), .NTONES(NT)) out_if ();

  mtx_phase_gen #(
    .PHASE_WIDTH(PW), .NTONES(NT), .NSYMB_WIDTH(NSW), .TX_SYNC_BITS(TSB),
    .NSYMB(NSYMB), .NSIG(NSIG), .START_PH_INC(SINC), .DPH_INC(DPH),
    .FREQ_SHIFT(FS), .START_PH(SPH), .NPH_SHIFT(NPHS), .NGUARD(NG)
  ) dut (
    .clk(clk), .reset(reset), .srst(srst), .en(en), .out(out_if),
    .symb_idx(symb_idx), .sig_idx(sig_idx), .frame_done(frame_done), .sync_ready(sync_ready)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   acc_count = 0;
  int   frames_pushed = 0;
  exp_t expq[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Closed-form phase of every tone for sample n of symbol s.
  function automatic logic [NT*PW-1:0] model_phase(int s, int n);
    logic [NT*PW-1:0] r;
    longint p;
    r = '0;
    for (int k = 0; k < NT; k++) begin
      p = longint'(SPH) - longint'(s) * NPHS + longint'(n) * (SINC + s * DPH + k * FS);
      r[k*PW +: PW] = p[PW-1:0];
    end
    return r;
  endfunction

  task automatic push_frame();
    exp_t e;
    logic sy;
    sy = (frames_pushed % (1 << TSB)) == 0;
    for (int s = 0; s < NSYMB; s++) begin
      for (int g = 0; g < GS; g++) begin
        e = '{phase: model_phase(s, 0), tlast: 1'b0, s: NSW'(s), n: '0, guard: 1'b1, sync: sy};
        expq.push_back(e);
      end
      for (int n = 0; n < NSIG; n++) begin
        e = '{phase: model_phase(s, n), tlast: (n == NSIG - 1), s: NSW'(s), n: PW'(n), guard: 1'b0, sync: sy};
        expq.push_back(e);
      end
    end
    frames_pushed++;
  endtask

  task automatic wait_acc(int target, string name);
    int cyc;
    cyc = 0;
    while (acc_count < target && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (acc_count < target) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout with %0d accepted, required %0d", name, acc_count, target);
    end
  endtask

  task automatic wait_drain(string name);
    int cyc;
    cyc = 0;
    while (expq.size() != 0 && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (expq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout with %0d samples outstanding, required 0", name, expq.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted sample, checks stall stability and pulses.
  initial begin
    exp_t             e;
    logic             fd_exp;
    logic             idle_exp;
    logic             prev_stall;
    logic [NT*PW-1:0] p_phase;
    logic             p_tlast;
    logic [NSW-1:0]   p_s;
    logic [PW-1:0]    p_n;
    fd_exp = 1'b0;
    idle_exp = 1'b0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || srst) begin
        fd_exp = 1'b0;
        idle_exp = 1'b0;
        prev_stall = 1'b0;
      end else begin
        check("frame_done", 64'(frame_done), 64'(fd_exp));
        fd_exp = 1'b0;
        if (idle_exp) check("tvalid_after_stop", 64'(out_if.tvalid), 64'd0);
        idle_exp = 1'b0;
        if (prev_stall) begin
          check("stall_tvalid", 64'(out_if.tvalid), 64'd1);
          check("stall_phase", 64'(out_if.phase), 64'(p_phase));
          check("stall_tlast", 64'(out_if.tlast), 64'(p_tlast));
          check("stall_symb", 64'(symb_idx), 64'(p_s));
          check("stall_sig", 64'(sig_idx), 64'(p_n));
        end
        if (out_if.tvalid && out_if.tready) begin
          acc_count++;
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_sample: phase %0h arrived, none expected", out_if.phase);
          end else begin
            e = expq.pop_front();
            check("phase", 64'(out_if.phase), 64'(e.phase));
            check("tlast", 64'(out_if.tlast), 64'(e.tlast));
            check("symb_idx", 64'(symb_idx), 64'(e.s));
            check("sig_idx", 64'(sig_idx), 64'(e.n));
            check("sync_ready", 64'(sync_ready), 64'(e.sync));
`ifdef MTX_GUARD_EN
            check("guard", 64'(out_if.guard), 64'(e.guard));
`endif
            fd_exp = e.tlast && (e.s == NSW'(NSYMB - 1));
            idle_exp = fd_exp && (expq.size() == 0);
          end
        end
        prev_stall = out_if.tvalid && !out_if.tready;
        p_phase = out_if.phase;
        p_tlast = out_if.tlast;
        p_s = symb_idx;
        p_n = sig_idx;
      end
    end
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(out_if.tvalid), 64'd0);
    check("rst_tlast", 64'(out_if.tlast), 64'd0);
    check("rst_phase", 64'(out_if.phase), 64'd0);
    check("rst_symb", 64'(symb_idx), 64'd0);
    check("rst_sig", 64'(sig_idx), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_sync_ready", 64'(sync_ready), 64'd1);
    reset = 1'b0;

    // One frame at full rate; en drops at sample 2 of symbol 0.
    base = acc_count;
    push_frame();
    en = 1'b1;
    wait_acc(base + 2, "wait_s0n2");
    en = 1'b0;
    wait_drain("drain_frame1");
    check("idle_tvalid", 64'(out_if.tvalid), 64'd0);

    // Five back-to-back frames under random backpressure, stop requested inside the last.
    rnd_ready = 1'b1;
    base = acc_count;
    for (int f = 0; f < 5; f++) push_frame();
    en = 1'b1;
    wait_acc(base + 4 * SPF + 3, "wait_frame5");
    en = 1'b0;
    wait_drain("drain_frames");
    check("idle_tvalid2", 64'(out_if.tvalid), 64'd0);

    // Mid-frame reset at symbol 1, n=2: once with reset, once with srst.
    for (int r = 0; r < 2; r++) begin
      base = acc_count;
      push_frame();
      en = 1'b1;
      wait_acc(base + (GS + NSIG) + GS + 2, "wait_s1n2");
      check("pre_rst_symb", 64'(symb_idx), 64'd1);
      check("pre_rst_sig", 64'(sig_idx), 64'd2);
      if (r == 0) reset = 1'b1;
      else srst = 1'b1;
      expq.delete();
      frames_pushed = 0;
      @(posedge clk);
      #1;
      check("mid_rst_tvalid", 64'(out_if.tvalid), 64'd0);
      check("mid_rst_phase", 64'(out_if.phase), 64'd0);
      check("mid_rst_sync", 64'(sync_ready), 64'd1);
      reset = 1'b0;
      srst = 1'b0;
      base = acc_count;
      push_frame();
      wait_acc(base + GS + 2, "wait_restart");
      en = 1'b0;
      wait_drain("drain_restart");
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
